serial_word_adder: RTL and testbench

SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

---
 rtl/serial_word_adder_pkg.sv | 12 +
 rtl/serial_word_adder_cla.sv | 29 ++
 rtl/serial_word_adder.sv | 106 ++++++++++
 tb/tb_serial_word_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_adder_pkg.sv
// Shared constants for the byte-serial adder: byte width, default word size
// and FSM state encodings, used by the RTL and the bench alike.
package serial_word_adder_pkg;
  localparam int BYTE_W        = 8;
  localparam int BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_word_adder_cla.sv
// 8-bit carry-lookahead adder stage: generate/propagate form, the carry
// recurrence is flattened into lookahead terms by synthesis.
module serial_word_adder_cla
  import serial_word_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] InputA,
  input  logic [BYTE_W-1:0] InputB,
  input  logic              InputCarry,
  output logic [BYTE_W-1:0] Sum,
  output logic              OutputCarry
);
  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   carry;

  assign gen  = InputA & InputB;
  assign prop = InputA ^ InputB;

  always_comb begin
    carry    = '0;
    carry[0] = InputCarry;
    for (int i = 0; i < BYTE_W; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign Sum         = prop ^ carry[BYTE_W-1:0];
  assign OutputCarry = carry[BYTE_W];
endmodule

// File: rtl/serial_word_adder.sv
// Byte-serial add/subtract: one byte per cycle through a single 8-bit CLA
// stage, with a valid/ready request port and a valid/ready result port.
module serial_word_adder
  import serial_word_adder_pkg::*;
#(
  parameter int BYTES = BYTES_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [BYTE_W*BYTES-1:0]   OperandA,
  input  logic [BYTE_W*BYTES-1:0]   OperandB,
  input  logic                      InputCarry,
  input  logic                      Subtract,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [BYTE_W*BYTES-1:0]   Result,
  output logic                      OutputCarry,
  output logic                      Overflow,
  output state_t                    DebugState
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends combinationally on valid, and a producer
  // holds valid until the transfer.
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  state_t state, state_next;

  logic [IW-1:0]                  idx;
  logic [BYTES-1:0][BYTE_W-1:0]   a_q, b_q, res_q;
  logic                           sub_q, carry_q;
  logic [BYTE_W-1:0]              a_byte, b_eff, sum;
  logic                           cout, last_byte;

  assign a_byte    = a_q[idx];
  assign b_eff     = b_q[idx] ^ {BYTE_W{sub_q}};
  assign last_byte = (idx == LAST);

  serial_word_adder_cla u_cla (
    .InputA      (a_byte),
    .InputB      (b_eff),
    .InputCarry  (carry_q),
    .Sum         (sum),
    .OutputCarry (cout)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (InValid)   state_next = ST_RUN;
      ST_RUN:  if (last_byte) state_next = ST_DONE;
      ST_DONE: if (OutReady)  state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  assign InReady    = (state == ST_IDLE);
  assign OutValid   = (state == ST_DONE);
  assign Result     = res_q;
  assign DebugState = state;

  // Subtract is A + ~B + 1, so the carry seeds to 1 and the caller's carry is dropped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      OutputCarry <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (InValid) begin
            a_q     <= OperandA;
            b_q     <= OperandB;
            sub_q   <= Subtract;
            carry_q <= Subtract | InputCarry;
            idx     <= '0;
          end
        end
        ST_RUN: begin
          res_q[idx] <= sum;
          carry_q    <= cout;
          if (last_byte) begin
            OutputCarry <= cout;
            Overflow    <= (a_byte[BYTE_W-1] == b_eff[BYTE_W-1]) &&
                           (sum[BYTE_W-1] != a_byte[BYTE_W-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder: vector table plus hand-written
// stall, same-edge request and mid-operation reset sequences.
module tb_serial_word_adder;
  import serial_word_adder_pkg::*;

  localparam int BYTES = BYTES_DEFAULT;
  localparam int W     = BYTE_W * BYTES;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         in_carry, subtract;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         out_carry, overflow;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  serial_word_adder #(.BYTES(BYTES)) dut (
    .Clock       (clock),
    .Reset       (reset_n),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .OperandA    (op_a),
    .OperandB    (op_b),
    .InputCarry  (in_carry),
    .Subtract    (subtract),
    .OutValid    (out_valid),
    .OutReady    (out_ready),
    .Result      (result),
    .OutputCarry (out_carry),
    .Overflow    (overflow),
    .DebugState  (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    op_a     = $urandom;
    op_b     = $urandom;
    in_carry = 1'($urandom_range(0, 1));
    subtract = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after an edge; returns #1 after the acceptance edge.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clock); #1; k++;
    end
    check({tag, " in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    in_carry = cin;
    subtract = sub;
    @(posedge clock); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clock); #1; cyc++;
    end
    check({tag, " latency"}, W'(cyc), W'(BYTES));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] res,
                              input logic cout, input logic ovf);
    check({tag, " result"}, result, res);
    check({tag, " carry"}, W'(out_carry), W'(cout));
    check({tag, " overflow"}, W'(overflow), W'(ovf));
  endtask

  task automatic release_op(input string tag);
    @(posedge clock); #1;
    check({tag, " back_to_idle"}, W'(in_ready), W'(1));
    check({tag, " valid_drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_000C, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0080, 32'h0000_007F, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    in_carry  = 1'b0;
    subtract  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset result", result, '0);
    check("reset carry", W'(out_carry), W'(0));
    check("reset overflow", W'(overflow), W'(0));
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_reset in_ready", W'(in_ready), W'(1));
    check("post_reset state", W'(dbg_state), W'(ST_IDLE));

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(tag, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check({tag, " busy"}, W'(in_ready), W'(0));
      wait_done(tag);
      check_result(tag, vecs[i].res, vecs[i].cout, vecs[i].ovf);
      release_op(tag);
    end

    // Stall in DONE with a pending request that must not be taken early.
    out_ready = 1'b0;
    start_op("stall", 32'hFFFF_0000, 32'h0002_0000, 1'b0, 1'b0);
    wait_done("stall");
    check_result("stall", 32'h0001_0000, 1'b1, 1'b0);
    in_valid = 1'b1;
    op_a     = 32'h0000_0010;
    op_b     = 32'h0000_0020;
    in_carry = 1'b0;
    subtract = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check("stall valid", W'(out_valid), W'(1));
      check("stall in_ready", W'(in_ready), W'(0));
      check("stall result", result, 32'h0001_0000);
      check("stall carry", W'(out_carry), W'(1));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("release idle", W'(in_ready), W'(1));
    check("release valid", W'(out_valid), W'(0));
    @(posedge clock); #1;
    check("next accepted", W'(dbg_state), W'(ST_RUN));
    in_valid = 1'b0;
    scramble_inputs();
    wait_done("next");
    check_result("next", 32'h0000_0030, 1'b0, 1'b0);
    release_op("next");

    // Abort two cycles into an operation.
    start_op("abort", 32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort state", W'(dbg_state), W'(ST_IDLE));
    check("abort valid", W'(out_valid), W'(0));
    check("abort result", result, '0);
    check("abort carry", W'(out_carry), W'(0));
    check("abort overflow", W'(overflow), W'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("abort hold valid", W'(out_valid), W'(0));
    end
    reset_n = 1'b1;
    start_op("after_abort", 32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0);
    wait_done("after_abort");
    check_result("after_abort", 32'h1223_3445, 1'b0, 1'b0);
    release_op("after_abort");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
